// File: rtl/qq_pkg.sv
// Shared types and constants for the QuickQ request arbiter.
// QQ_ARB_TIMEOUT_EN is the only consumer of the watchdog constants below.
package qq_pkg;

  typedef enum logic {
    OP_ENQ = 1'b0,
    OP_DEQ = 1'b1
  } op_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_ISSUE = 2'd1;
  localparam arb_state_t ST_WAIT  = 2'd2;
  localparam arb_state_t ST_RESP  = 2'd3;

  localparam int unsigned TIMEOUT_CYCLES = 1000;
  localparam int unsigned WDOG_W         = 16;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qq_req_arbiter_if.sv
// Requester-side and QuickQ-side handshake bundle for qq_req_arbiter.
// slave = arbiter view, master = requesters plus QuickQ control FSM.
interface qq_req_arbiter_if #(
  parameter int NREQ = 4,
  parameter int KEYW = 16
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_op;
  logic [NREQ*KEYW-1:0] req_key;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [KEYW-1:0]      rsp_key;
  logic                 rsp_err;
  logic                 q_enq;
  logic                 q_deq;
  logic [KEYW-1:0]      q_key;
  logic                 q_done;
  logic [KEYW-1:0]      q_deq_key;

  modport slave (
    input  req_valid, req_op, req_key, q_done, q_deq_key,
    output req_ready, rsp_valid, rsp_key, rsp_err, q_enq, q_deq, q_key
  );

  modport master (
    output req_valid, req_op, req_key, q_done, q_deq_key,
    input  req_ready, rsp_valid, rsp_key, rsp_err, q_enq, q_deq, q_key
  );
endinterface

// File: rtl/qq_rr_arb.sv
// Combinational round-robin pick: first valid requester at or after i_ptr,
// wrapping modulo NREQ.
module qq_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req_valid,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    logic [IW-1:0] w_j;
    w_j     = '0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_j = IW'((int'(i_ptr) + i) % NREQ);
      if (!o_any && i_req_valid[w_j]) begin
        o_any        = 1'b1;
        o_idx        = w_j;
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qq_req_arbiter.sv
// Round-robin arbiter serialising NREQ requesters onto one QuickQ and tracking occupancy.
// Define QQ_ARB_TIMEOUT_EN to add a WAIT watchdog and the sticky o_timeout_flag port.
//
// state    | meaning
// IDLE     | no command in flight; grant next requester round-robin
// ISSUE    | pulse q_enq/q_deq, or reject on full/empty
// WAIT     | waiting for q_done from the QuickQ
// RESP     | pulse rsp_valid to the winner, advance rr pointer
module qq_req_arbiter
  import qq_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int KEYW  = 16,
  parameter int DEPTH = 64,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int IW   = idx_w(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  qq_req_arbiter_if.slave     io_bus,
  output logic [CW-1:0]       o_count,
  output logic                o_full,
  output logic                o_empty
`ifdef QQ_ARB_TIMEOUT_EN
  ,
  output logic                o_timeout_flag
`endif
);

  arb_state_t      r_state;
  logic [IW-1:0]   r_winner;
  logic [IW-1:0]   r_rr_ptr;
  op_t             r_op;
  logic [KEYW-1:0] r_key;
  logic [KEYW-1:0] r_rsp_key;
  logic            r_err;
  logic [CW-1:0]   r_count;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_full;
  logic            w_empty;
  logic            w_reject;

`ifdef QQ_ARB_TIMEOUT_EN
  logic [WDOG_W-1:0] r_wdog;
  logic              r_timeout_flag;
  assign o_timeout_flag = r_timeout_flag;
`endif

  qq_rr_arb #(.NREQ(NREQ), .IW(IW)) u_rr_arb (
    .i_req_valid (io_bus.req_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_idx       (w_idx),
    .o_any       (w_any)
  );

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_reject = (r_op == OP_ENQ) ? w_full : w_empty;
  assign o_count  = r_count;
  assign o_full   = w_full;
  assign o_empty  = w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_winner  <= '0;
      r_rr_ptr  <= '0;
      r_op      <= OP_ENQ;
      r_key     <= '0;
      r_rsp_key <= '0;
      r_err     <= 1'b0;
      r_count   <= '0;
`ifdef QQ_ARB_TIMEOUT_EN
      r_wdog         <= '0;
      r_timeout_flag <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_winner  <= w_idx;
            r_op      <= op_t'(io_bus.req_op[w_idx]);
            r_key     <= io_bus.req_key[w_idx*KEYW +: KEYW];
            r_rsp_key <= '0;
            r_err     <= 1'b0;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_reject) begin
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_state <= ST_WAIT;
`ifdef QQ_ARB_TIMEOUT_EN
            r_wdog  <= WDOG_W'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
        ST_WAIT: begin
          if (io_bus.q_done) begin
            if (r_op == OP_DEQ) begin
              r_rsp_key <= io_bus.q_deq_key;
              r_count   <= r_count - CW'(1);
            end else begin
              r_count   <= r_count + CW'(1);
            end
            r_state <= ST_RESP;
          end
`ifdef QQ_ARB_TIMEOUT_EN
          else if (r_wdog == '0) begin
            r_err          <= 1'b1;
            r_timeout_flag <= 1'b1;
            r_state        <= ST_RESP;
          end else begin
            r_wdog <= r_wdog - WDOG_W'(1);
          end
`endif
        end
        ST_RESP: begin
          r_rr_ptr <= (r_winner == IW'(NREQ - 1)) ? '0 : r_winner + IW'(1);
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from state and forced quiet while rst is high so an
  // abandoned command never shows a pulse.
  always_comb begin
    io_bus.req_ready = '0;
    io_bus.rsp_valid = '0;
    io_bus.rsp_key   = '0;
    io_bus.rsp_err   = 1'b0;
    io_bus.q_enq     = 1'b0;
    io_bus.q_deq     = 1'b0;
    io_bus.q_key     = '0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: io_bus.req_ready = w_grant;
        ST_ISSUE: begin
          if (!w_reject) begin
            io_bus.q_enq = (r_op == OP_ENQ);
            io_bus.q_deq = (r_op == OP_DEQ);
            io_bus.q_key = (r_op == OP_ENQ) ? r_key : '0;
          end
        end
        ST_RESP: begin
          io_bus.rsp_valid = NREQ'(1) << r_winner;
          io_bus.rsp_err   = r_err;
          io_bus.rsp_key   = r_rsp_key;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qq_req_arbiter.sv
// Self-checking bench for qq_req_arbiter; the bench plays both the requesters and the QuickQ.
// Define QQ_ARB_TIMEOUT_EN to also exercise the WAIT watchdog.
`timescale 1ns/1ps
module tb_qq_req_arbiter;
  localparam int NREQ  = 4;
  localparam int KEYW  = 16;
  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
`ifdef QQ_ARB_TIMEOUT_EN
  logic          timeout_flag;
`endif

  qq_req_arbiter_if #(.NREQ(NREQ), .KEYW(KEYW)) bus ();

  qq_req_arbiter #(.NREQ(NREQ), .KEYW(KEYW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_bus  (bus),
    .o_count (count),
    .o_full  (full),
    .o_empty (empty)
`ifdef QQ_ARB_TIMEOUT_EN
    ,
    .o_timeout_flag (timeout_flag)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [KEYW-1:0] mq[$];   // QuickQ contents as seen by the bench
  int exp_ptr = 0;          // round-robin start point per the arbitration rule

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v);
    int j;
    for (int k = 0; k < NREQ; k++) begin
      j = (exp_ptr + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst            = 1'b1;
    bus.req_valid  = '1;
    bus.req_op     = '0;
    bus.req_key    = '0;
    bus.q_done     = 1'b0;
    bus.q_deq_key  = '0;
    step();
    step();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_q", {bus.q_enq, bus.q_deq, bus.q_key}, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_key}, 0);
    chk("rst_count", count, 0);
    chk("rst_flags", {full, empty}, 2'b01);
    rst           = 1'b0;
    bus.req_valid = '0;
    mq.delete();
    exp_ptr = 0;
  endtask

  task automatic idle(input int n);
    bus.req_valid = '0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("idle_quiet", {bus.req_ready, bus.rsp_valid, bus.q_enq, bus.q_deq}, 0);
      step();
    end
  endtask

  // One complete command: accept, issue (or reject), optional wait, response.
  task automatic do_cmd(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] ops,
                        input logic [NREQ*KEYW-1:0] keys, input int delay, input bit glitch);
    int              w;
    logic            op;
    logic [KEYW-1:0] key;
    logic [KEYW-1:0] rkey;
    bit              reject;
    bus.req_valid = valid;
    bus.req_op    = ops;
    bus.req_key   = keys;
    #1;
    w   = pick(valid);
    op  = ops[w[1:0]];
    key = keys[w*KEYW +: KEYW];
    chk("accept_ready", bus.req_ready, 64'(1) << w);
    step();
    bus.req_op  = NREQ'($urandom);
    bus.req_key = {$urandom, $urandom};
    reject = (op == 1'b0 && mq.size() == DEPTH) || (op == 1'b1 && mq.size() == 0);
    chk("issue_enq", bus.q_enq, !reject && op == 1'b0);
    chk("issue_deq", bus.q_deq, !reject && op == 1'b1);
    if (!reject && op == 1'b0) chk("issue_key", bus.q_key, key);
    if (glitch) begin
      bus.q_done    = 1'b1;
      bus.q_deq_key = KEYW'($urandom);
    end
    step();
    bus.q_done = 1'b0;
    rkey = '0;
    if (!reject) begin
      for (int d = 0; d < delay; d++) begin
        chk("wait_quiet", {bus.q_enq, bus.q_deq, bus.rsp_valid}, 0);
        step();
      end
      if (op == 1'b1) begin
        rkey          = mq.pop_front();
        bus.q_deq_key = rkey;
      end else begin
        mq.push_back(key);
        bus.q_deq_key = KEYW'($urandom);
      end
      bus.q_done = 1'b1;
      step();
      bus.q_done = 1'b0;
    end
    chk("rsp_valid", bus.rsp_valid, 64'(1) << w);
    chk("rsp_err", bus.rsp_err, reject);
    chk("rsp_key", bus.rsp_key, rkey);
    chk("count", count, mq.size());
    chk("full_empty", {full, empty}, {mq.size() == DEPTH, mq.size() == 0});
    exp_ptr = (w + 1) % NREQ;
    step();
  endtask

  initial begin
    logic [NREQ-1:0] v;
    int n;

    do_reset();

    // dequeue from empty is rejected without a q_deq pulse
    do_cmd(4'b0010, 4'b0010, {$urandom, $urandom}, 0, 1'b0);
    // requester 2 enqueues 0x0042 from empty
    do_cmd(4'b0100, 4'b0000, {16'h0, 16'h0042, 16'h0, 16'h0}, 0, 1'b0);
    do_cmd(4'b1000, 4'b1000, {$urandom, $urandom}, 1, 1'b0);
    // enqueue then dequeue the same key
    do_cmd(4'b0001, 4'b0000, {48'h0, 16'h0010}, 2, 1'b0);
    do_cmd(4'b0001, 4'b0001, {$urandom, $urandom}, 0, 1'b0);
    chk("empty_again", count, 0);

    do_reset();
    // requesters 0,1,3 continuously valid: grants 0,1,3,0
    bus.req_valid = 4'b1011;
    #1;
    chk("rr_first", bus.req_ready, 4'b0001);
    do_cmd(4'b1011, 4'b0000, {$urandom, $urandom}, 0, 1'b0);
    chk("rr_second", bus.req_ready, 4'b0010);
    do_cmd(4'b1011, 4'b0000, {$urandom, $urandom}, 0, 1'b0);
    chk("rr_third", bus.req_ready, 4'b1000);
    do_cmd(4'b1011, 4'b0000, {$urandom, $urandom}, 0, 1'b0);
    chk("rr_fourth", bus.req_ready, 4'b0001);
    do_cmd(4'b1011, 4'b0000, {$urandom, $urandom}, 0, 1'b0);

    // randomized mix with idle gaps and stray q_done pulses
    for (int i = 0; i < 150; i++) begin
      v = NREQ'($urandom_range(1, 15));
      do_cmd(v, NREQ'($urandom), {$urandom, $urandom}, $urandom_range(0, 3),
             $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // fill to capacity, then an enqueue must be rejected
    while (mq.size() < DEPTH)
      do_cmd(NREQ'($urandom_range(1, 15)), 4'b0000, {$urandom, $urandom}, 0, 1'b0);
    do_cmd(NREQ'($urandom_range(1, 15)), 4'b0000, {4{16'h0007}}, 0, 1'b0);
    chk("full_hold", {full, count}, {1'b1, CW'(DEPTH)});
    while (mq.size() > 0)
      do_cmd(NREQ'($urandom_range(1, 15)), 4'b1111, {$urandom, $urandom},
             $urandom_range(0, 2), 1'b0);

    // reset while waiting on q_done abandons the command
    do_cmd(4'b0001, 4'b0000, {$urandom, $urandom}, 0, 1'b0);
    bus.req_valid = 4'b0100;
    bus.req_op    = 4'b0000;
    #1;
    step();
    bus.req_valid = '0;
    step();
    rst = 1'b1;
    step();
    rst           = 1'b0;
    bus.q_done    = 1'b1;
    bus.q_deq_key = 16'h1234;
    step();
    bus.q_done = 1'b0;
    chk("rst_wait_rsp", bus.rsp_valid, 0);
    chk("rst_wait_count", count, 0);
    step();
    chk("rst_wait_rsp2", bus.rsp_valid, 0);
    mq.delete();
    exp_ptr = 0;
    do_cmd(4'b1010, 4'b0000, {$urandom, $urandom}, 0, 1'b0);

`ifdef QQ_ARB_TIMEOUT_EN
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_op    = 4'b0000;
    #1;
    chk("to_ready", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = '0;
    chk("to_enq", bus.q_enq, 1'b1);
    n = 0;
    for (int i = 1; i <= 1100; i++) begin
      step();
      if (bus.rsp_valid != '0) begin
        n = i;
        break;
      end
    end
    chk("to_latency", n, 1001);
    chk("to_err", bus.rsp_err, 1'b1);
    chk("to_flag", timeout_flag, 1'b1);
    chk("to_count", count, 0);
    step();
    chk("to_sticky", timeout_flag, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qq_req_arbiter.md
QQ_REQ_ARBITER -- requirements
Module: qq_req_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one QuickQ.
REQ-002 Parameter KEYW, default 16: key width in bits.
REQ-003 Parameter DEPTH, default 64: QuickQ capacity in entries; CW = $clog2(DEPTH+1).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  NREQ  requester i holds a command.
REQ-008 req_op  in  NREQ  per-requester op: 0=enqueue, 1=dequeue.
REQ-009 req_key  in  NREQ*KEYW  per-requester enqueue key, slice i = [i*KEYW +: KEYW].
REQ-010 req_ready  out  NREQ  one-hot, one-cycle accept pulse to the granted requester.
REQ-011 rsp_valid  out  NREQ  one-hot, one-cycle completion pulse to the granted requester.
REQ-012 rsp_key  out  KEYW  dequeued key, valid with rsp_valid on a successful dequeue, else 0.
REQ-013 rsp_err  out  1  command rejected or aborted, valid with rsp_valid.
REQ-014 q_enq / q_deq  out  1 each  one-cycle command pulses to the QuickQ control FSM.
REQ-015 q_key  out  KEYW  key accompanying q_enq.
REQ-016 q_done  in  1  one-cycle completion pulse from the QuickQ control FSM.
REQ-017 q_deq_key  in  KEYW  key returned by QuickQ, sampled when q_done is high.
REQ-018 count  out  CW  current occupancy; full = (count==DEPTH), empty = (count==0), both outputs.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: if any req_valid, select winner round-robin starting at pointer rr_ptr, pulse req_ready[winner], latch winner/op/key, go to ISSUE; else stay.
REQ-021 ISSUE: enqueue while full or dequeue while empty -> set err, go to RESP without pulsing q_enq/q_deq; otherwise pulse q_enq or q_deq for exactly one cycle with q_key = latched key, go to WAIT.
REQ-022 WAIT: hold all q_* outputs low; on q_done, capture q_deq_key for a dequeue, count += 1 (enqueue) or -= 1 (dequeue), go to RESP.
REQ-023 RESP: pulse rsp_valid[winner] one cycle with rsp_err/rsp_key; rr_ptr <= (winner+1) mod NREQ; go to IDLE.
REQ-024 Latency: accept to q_enq/q_deq = 1 cycle; q_done to rsp_valid = 1 cycle; rejected command accept to rsp_valid = 2 cycles.
REQ-025 Only one command in flight; req_valid of other requesters is ignored outside IDLE.
REQ-026 Requester i holds req_valid/req_op/req_key stable until req_ready[i]; inputs changing afterwards have no effect on the in-flight command.
REQ-027 q_done outside WAIT is ignored and changes no state or count.
REQ-028 count never wraps: it is only updated in WAIT, which full/empty checks in ISSUE guard.

Reset
REQ-029 On rst: state=IDLE, rr_ptr=0, count=0, all outputs 0, latched winner/op/key cleared.
REQ-030 rst during ISSUE/WAIT/RESP abandons the command with no response; the QuickQ shares rst and is emptied likewise.

Configuration
REQ-031 Macro QQ_ARB_TIMEOUT_EN defined: a CW-independent 16-bit watchdog counts WAIT cycles; reaching 1000 without q_done goes to RESP with rsp_err=1, count unchanged, and sets sticky output timeout_flag (cleared only by rst).
REQ-032 QQ_ARB_TIMEOUT_EN undefined: no watchdog, no timeout_flag port; WAIT persists until q_done.

Structure
REQ-033 Package qq_pkg holds the op typedef (OP_ENQ, OP_DEQ), the arbiter state typedef and the timeout constant.
REQ-034 Sub-module qq_rr_arb: combinational NREQ-wide round-robin pick from req_valid and rr_ptr, producing one-hot grant and index.

Verification
REQ-035 Requester 2 enqueues key 0x0042 from empty -> req_ready=0100, next cycle q_enq=1 q_key=0x0042, q_done -> rsp_valid=0100 rsp_err=0 count=1.
REQ-036 Requesters 0,1,3 all valid continuously with rr_ptr=0 -> grant order 0,1,3,0 over four commands.
REQ-037 Dequeue with count=0 -> no q_deq pulse, rsp_valid two cycles after req_ready with rsp_err=1, count stays 0.
REQ-038 Fill to count=64, enqueue key 0x0007 -> rsp_err=1, count stays 64, full stays 1.
REQ-039 Enqueue 0x0010, then dequeue with q_deq_key=0x0010 on q_done -> rsp_key=0x0010, count returns to 0.
REQ-040 rst asserted in WAIT, then q_done -> no rsp_valid, state IDLE, count=0; with QQ_ARB_TIMEOUT_EN and no q_done -> rsp_err=1 after 1000 WAIT cycles, timeout_flag=1.
